ad5683_spi_rx: RTL and testbench
================================

Name: ad5683_spi_rx

Overview:
- SPI responder (slave-side decoder) for the 24-bit AD5683 write protocol driven by the ref-PLL DAC SPI master.
- Oversamples sclk/mosi/sync_n on the fabric clock, decodes each frame into command and data fields, and models the DAC input, DAC and control registers.
- Used as a loopback monitor to capture the DAC code actually sent.
- Used as the bench/fabric stand-in for the AD5683 when the real part is absent.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per SPI input (min 2).
- DAC_RESET, 16'h0000, reset value of input_reg and dac_reg.
- FRAME_BITS, 24, bits per valid frame (fixed 24 for AD5683; minimum is 8).

Ports:
- clk  in  1  fabric clock; must be ≥4× sclk frequency.
- reset_n  in  1  synchronous reset, active-low.
- sclk  in  1  SPI clock from master, asynchronous to clk.
- mosi  in  1  SPI data, MSB first, sampled on sclk falling edge.
- sync_n  in  1  SPI frame select, active-low.
- cmd  out  4  command field (DB23..DB20) of last good frame.
- data  out  16  data field (DB19..DB4) of last good frame.
- frame_valid  out  1  one-cycle pulse: good frame decoded.
- frame_err  out  1  one-cycle pulse: malformed frame.
- err_long  out  1  qualifies frame_err: 1 = too many bits, 0 = too few.
- input_reg  out  16  modelled DAC input register.
- dac_reg  out  16  modelled DAC output register (the "analog" code).
- ctrl_reg  out  4  modelled control register (DB19..DB16 of cmd 0100).
- frame_count  out  16  count of good frames, wraps 16'hFFFF→0.

Behaviour:
- Reset (reset_n low at a clk edge):
  - cmd, data, ctrl_reg, frame_count = 0.
  - input_reg = dac_reg = DAC_RESET.
  - Pulses and err_long = 0.
  - Synchronizer flops and edge-detect history reset to sclk=1, sync_n=1.
  - FSM goes to IDLE. A frame in progress at reset is discarded and produces no pulse.
- Input path:
  - Each input passes through SYNC_STAGES flops, then one history flop for edge detection.
  - sclk falling edge = history 1, current 0.
  - sync_n falling and rising edges are detected the same way.
- FSM states: IDLE, SHIFT, OVER.
  - IDLE: sclk edges are ignored. sync_n fall → SHIFT, bit_cnt (5 bit) = 0, shift reg (24 bit) = 0.
  - SHIFT: on each sclk fall, shift = {shift[22:0], mosi_sync} and bit_cnt+1. An sclk fall when bit_cnt == FRAME_BITS → OVER, with no shift.
  - SHIFT, on sync_n rise:
    - bit_cnt == FRAME_BITS → decode, frame_valid.
    - Otherwise frame_err with err_long=0.
    - Either way → IDLE.
  - OVER: sclk edges are ignored. sync_n rise → frame_err with err_long=1 → IDLE.
- Simultaneous events:
  - If an sclk fall and a sync_n rise are detected in the same cycle, the sclk fall is ignored.
  - If sync_n fall is detected in the cycle a pulse is issued, the new frame starts normally. Back-to-back frames are supported.
- Decode (same cycle as frame_valid, all registered):
  - cmd = shift[23:20], data = shift[19:4]. shift[3:0] is don't-care.
  - frame_count += 1.
  - 0001: input_reg = data.
  - 0010: dac_reg = input_reg.
  - 0011: input_reg = dac_reg = data.
  - 0100: ctrl_reg = shift[19:16].
  - 0000 and all others: no register change.
- Pulse and output rules:
  - frame_err does not change cmd, data, model registers or frame_count.
  - err_long holds until the next frame_err.
  - frame_valid and frame_err are never high together.
  - Each pulse is high for exactly one cycle.
- Latency: the pulse asserts SYNC_STAGES+2 clk cycles after the first clk edge that samples sync_n high at the pin.
- Glitch rules:
  - sync_n high pulses shorter than 1 clk may be missed; this is allowed.
  - sclk must stay high ≥2 clk and low ≥2 clk.

Test Plan:
- Reset mid-frame: reset_n low after 10 sclk bits, then released, then a new frame → no pulse for the aborted frame; outputs hold reset values until the new frame decodes.
- Write-through: frame 0x3_7FFF_0 (cmd 0011, data 16'h7FFF) at sclk = clk/8 → one frame_valid; cmd=3; data=16'h7FFF; input_reg = dac_reg = 16'h7FFF; frame_count=1.
- Staged update:
  - Frame cmd 0001, data 16'h1234 → input_reg=16'h1234, dac_reg unchanged.
  - Then frame cmd 0010, data 16'h0000 → dac_reg=16'h1234.
- Short/long frames: 23 bits then sync_n rise → frame_err, err_long=0. 25 bits → frame_err, err_long=1. For both: state unchanged and frame_count unchanged.
- Back-to-back and wrap: preload count to 16'hFFFE via 65534 frames (or force), then send two frames with 1 sclk period of sync_n high between them → two frame_valid pulses; frame_count wraps to 16'h0000.
- Latency/edge case: with SYNC_STAGES=2, measure sync_n rise to frame_valid = 4 clk. Also send an sclk fall coincident with sync_n rise → the bit is not counted.

Source files
------------

// File: rtl/ad5683_spi_rx.sv
`default_nettype none
//==============================================================================
// Module  : ad5683_spi_rx
// Brief   : Oversampling SPI responder for the 24-bit AD5683 write protocol;
//           decodes frames and models the DAC input, DAC and control registers.
// Revision: 1.0 - initial release
//==============================================================================
module ad5683_spi_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DAC_RESET   = 16'h0000,
    parameter int          FRAME_BITS  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        sync_n,
    output logic [3:0]  cmd,
    output logic [15:0] data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        err_long,
    output logic [15:0] input_reg,
    output logic [15:0] dac_reg,
    output logic [3:0]  ctrl_reg,
    output logic [15:0] frame_count
);

    localparam logic [4:0] c_frame_bits = 5'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sync_n_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_sync_n_hist;
    logic                   r_sclk_fall;
    logic                   r_sync_fall;
    logic                   r_sync_rise;
    logic                   r_mosi_bit;

    logic w_sclk_cur;
    logic w_sync_n_cur;
    logic w_mosi_cur;

    assign w_sclk_cur   = r_sclk_sync[SYNC_STAGES-1];
    assign w_sync_n_cur = r_sync_n_sync[SYNC_STAGES-1];
    assign w_mosi_cur   = r_mosi_sync[SYNC_STAGES-1];

    // Edge strobes are registered together with the matching mosi sample so
    // the FSM always sees the data bit that was present at the sclk fall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sclk_sync   <= '1;
            r_sync_n_sync <= '1;
            r_mosi_sync   <= '0;
            r_sclk_hist   <= 1'b1;
            r_sync_n_hist <= 1'b1;
            r_sclk_fall   <= 1'b0;
            r_sync_fall   <= 1'b0;
            r_sync_rise   <= 1'b0;
            r_mosi_bit    <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_sync_n_sync <= {r_sync_n_sync[SYNC_STAGES-2:0], sync_n};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_hist   <= w_sclk_cur;
            r_sync_n_hist <= w_sync_n_cur;
            r_sclk_fall   <= r_sclk_hist & ~w_sclk_cur;
            r_sync_fall   <= r_sync_n_hist & ~w_sync_n_cur;
            r_sync_rise   <= ~r_sync_n_hist & w_sync_n_cur;
            r_mosi_bit    <= w_mosi_cur;
        end
    end

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [23:0] r_shift, w_shift_nxt;
    logic        r_end_ok, w_end_ok;
    logic        r_end_err, w_end_err;
    logic        r_end_long, w_end_long;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 5'd0;
            r_shift    <= 24'd0;
            r_end_ok   <= 1'b0;
            r_end_err  <= 1'b0;
            r_end_long <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_end_ok   <= w_end_ok;
            r_end_err  <= w_end_err;
            r_end_long <= w_end_long;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_end_ok      = 1'b0;
        w_end_err     = 1'b0;
        w_end_long    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync_fall) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_cnt_nxt = 5'd0;
                    w_shift_nxt   = 24'd0;
                end
            end
            ST_SHIFT: begin
                // Frame end wins over a coincident sclk fall.
                if (r_sync_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (r_bit_cnt == c_frame_bits) begin
                        w_end_ok = 1'b1;
                    end else begin
                        w_end_err = 1'b1;
                    end
                end else if (r_sclk_fall) begin
                    if (r_bit_cnt == c_frame_bits) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_shift_nxt   = {r_shift[22:0], r_mosi_bit};
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
            end
            ST_OVER: begin
                if (r_sync_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_end_err   = 1'b1;
                    w_end_long  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd         <= 4'd0;
            data        <= 16'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_long    <= 1'b0;
            input_reg   <= DAC_RESET;
            dac_reg     <= DAC_RESET;
            ctrl_reg    <= 4'd0;
            frame_count <= 16'd0;
        end else begin
            frame_valid <= r_end_ok;
            frame_err   <= r_end_err;
            if (r_end_err) begin
                err_long <= r_end_long;
            end
            if (r_end_ok) begin
                cmd         <= r_shift[23:20];
                data        <= r_shift[19:4];
                frame_count <= frame_count + 16'd1;
                case (r_shift[23:20])
                    4'b0001: input_reg <= r_shift[19:4];
                    4'b0010: dac_reg   <= input_reg;
                    4'b0011: begin
                        input_reg <= r_shift[19:4];
                        dac_reg   <= r_shift[19:4];
                    end
                    4'b0100: ctrl_reg  <= r_shift[19:16];
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad5683_spi_rx.sv
`default_nettype none
//==============================================================================
// Module  : tb_ad5683_spi_rx
// Brief   : Randomized self-checking bench for ad5683_spi_rx against a
//           frame-level register model.
// Revision: 1.0 - initial release
//==============================================================================
module tb_ad5683_spi_rx;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk    = 1'b1;
    logic        mosi    = 1'b0;
    logic        sync_n  = 1'b1;
    logic [3:0]  cmd;
    logic [15:0] data;
    logic        frame_valid;
    logic        frame_err;
    logic        err_long;
    logic [15:0] input_reg;
    logic [15:0] dac_reg;
    logic [3:0]  ctrl_reg;
    logic [15:0] frame_count;

    ad5683_spi_rx #(
        .SYNC_STAGES(2),
        .DAC_RESET  (16'h0000),
        .FRAME_BITS (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sclk       (sclk),
        .mosi       (mosi),
        .sync_n     (sync_n),
        .cmd        (cmd),
        .data       (data),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .err_long   (err_long),
        .input_reg  (input_reg),
        .dac_reg    (dac_reg),
        .ctrl_reg   (ctrl_reg),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;
    int hp      = 40;

    logic [3:0]  m_cmd;
    logic [15:0] m_data;
    logic [15:0] m_in;
    logic [15:0] m_dac;
    logic [3:0]  m_ctrl;
    logic [15:0] m_count;
    logic        m_long;

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (frame_valid && frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cmd = 4'd0; m_data = 16'd0; m_in = 16'h0000; m_dac = 16'h0000;
        m_ctrl = 4'd0; m_count = 16'd0; m_long = 1'b0;
    endtask

    // Frame-level model: exactly 24 bits decodes, anything else is an error.
    task automatic model_frame(input logic [31:0] word, input int nbits);
        logic [3:0]  c;
        logic [15:0] d;
        if (nbits == 24) begin
            c = word[23:20];
            d = word[19:4];
            m_cmd = c;
            m_data = d;
            m_count = m_count + 16'd1;
            if (c == 4'd1) m_in = d;
            else if (c == 4'd2) m_dac = m_in;
            else if (c == 4'd3) begin m_in = d; m_dac = d; end
            else if (c == 4'd4) m_ctrl = word[19:16];
        end else begin
            m_long = (nbits > 24);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".cmd"}, 32'(cmd), 32'(m_cmd));
        check({tag, ".data"}, 32'(data), 32'(m_data));
        check({tag, ".input_reg"}, 32'(input_reg), 32'(m_in));
        check({tag, ".dac_reg"}, 32'(dac_reg), 32'(m_dac));
        check({tag, ".ctrl_reg"}, 32'(ctrl_reg), 32'(m_ctrl));
        check({tag, ".frame_count"}, 32'(frame_count), 32'(m_count));
        check({tag, ".err_long"}, 32'(err_long), 32'(m_long));
    endtask

    task automatic shift_bits(input logic [31:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            sclk = 1'b1;
            #(hp);
            sclk = 1'b0;
            #(hp);
        end
        sclk = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits);
        sync_n = 1'b0;
        #(hp);
        shift_bits(word, nbits);
        #(hp);
        sync_n = 1'b1;
        #(2 * hp);
    endtask

    task automatic run_frame(input logic [31:0] word, input int nbits, input string tag);
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(word, nbits);
        repeat (12) @(negedge clk);
        model_frame(word, nbits);
        check({tag, ".valid_pulses"}, 32'(n_valid - v0), (nbits == 24) ? 32'd1 : 32'd0);
        check({tag, ".err_pulses"}, 32'(n_err - e0), (nbits == 24) ? 32'd0 : 32'd1);
        check_state(tag);
    endtask

    initial begin
        logic [31:0] word;
        int          nbits;
        int          v0;
        int          e0;
        int          lat;
        bit          found;

        model_reset();
        repeat (4) @(negedge clk);
        check_state("reset");
        check("reset.frame_valid", 32'(frame_valid), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(32'h0037_FFF0, 24, "write_through");

        // Abort a frame after 10 bits by asserting reset.
        v0 = n_valid;
        e0 = n_err;
        sync_n = 1'b0;
        #(hp);
        shift_bits($urandom, 10);
        @(negedge clk);
        reset_n = 1'b0;
        sync_n  = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        model_reset();
        check("rst_mid.valid_pulses", 32'(n_valid - v0), 32'd0);
        check("rst_mid.err_pulses", 32'(n_err - e0), 32'd0);
        check_state("rst_mid");

        run_frame(32'h0011_2340, 24, "stage_load");
        run_frame(32'h0020_0000, 24, "stage_update");
        run_frame($urandom, 23, "short");
        run_frame($urandom, 25, "long");
        run_frame(32'h0040_0005 | ($urandom & 32'h000F_FFF0), 24, "ctrl");

        // Final sclk fall lands together with the sync_n rise.
        v0 = n_valid;
        e0 = n_err;
        word = 32'h0013_5790;
        sync_n = 1'b0;
        #(hp);
        shift_bits(word, 24);
        mosi = 1'b1;
        #(hp);
        sclk   = 1'b0;
        sync_n = 1'b1;
        #(hp);
        sclk = 1'b1;
        repeat (12) @(negedge clk);
        model_frame(word, 24);
        check("coincident.valid_pulses", 32'(n_valid - v0), 32'd1);
        check("coincident.err_pulses", 32'(n_err - e0), 32'd0);
        check_state("coincident");

        // Latency from the first clk edge sampling sync_n high.
        word = 32'h0030_ABC0;
        sync_n = 1'b0;
        #(hp);
        shift_bits(word, 24);
        #(hp);
        @(negedge clk);
        sync_n = 1'b1;
        @(posedge clk);
        lat = 0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (frame_valid) found = 1'b1;
        end
        check("latency", 32'(lat), 32'd4);
        repeat (8) @(negedge clk);
        model_frame(word, 24);
        check_state("latency");

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                0:       nbits = 23;
                1:       nbits = 25;
                2:       nbits = $urandom_range(1, 22);
                default: nbits = 24;
            endcase
            hp = 30 + 10 * $urandom_range(0, 1);
            word = $urandom;
            word[23:20] = 4'($urandom_range(0, 7));
            run_frame(word, nbits, $sformatf("rand%0d", n));
        end
        hp = 40;

        // Back-to-back frames across the frame_count wrap.
        force dut.frame_count = 16'hFFFE;
        @(negedge clk);
        release dut.frame_count;
        m_count = 16'hFFFE;
        v0 = n_valid;
        send_frame(32'h0010_0010, 24);
        send_frame(32'h0032_2220, 24);
        repeat (12) @(negedge clk);
        model_frame(32'h0010_0010, 24);
        model_frame(32'h0032_2220, 24);
        check("wrap.valid_pulses", 32'(n_valid - v0), 32'd2);
        check_state("wrap");

        check("pulse_overlap", 32'(n_both), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
